// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encoding, RAM
// geometry and a small grant helper.
package ram_arbiter_pkg;

  // Access sequencer states; 2'd3 is unused and decodes back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int DATA_W    = 32;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = DATA_W / NUM_LANES;
  localparam int NUM_PORTS = 2;

  // Index of the winning port from a one-hot two-port grant.
  function automatic logic grant_port(input logic [1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/ram_arbiter_rr.sv
// Two-requester arbiter: round-robin on ties unless fixed_priority, in
// which case port 0 always wins. Purely combinational.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_priority,
  output logic [1:0] grant
);

  // One-hot winner; on a tie the port that did not win last time goes next.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (fixed_priority || last_grant) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between two picorv32-style native memory
// requesters. One access at a time: IDLE (arbitrate and latch) -> ISSUE
// (RAM cycle) -> RESP (one-cycle ready with pass-through read data).
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 13,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clk_cpu,
  input  logic                  resetn,
  input  logic                  m0_valid,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [NUM_LANES-1:0]  m0_wstrb,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic                  m0_ready,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_valid,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [NUM_LANES-1:0]  m1_wstrb,
  input  logic [DATA_W-1:0]     m1_wdata,
  output logic                  m1_ready,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  ram_sel,
  output logic [NUM_LANES-1:0]  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic                  grant_id
);

  state_t state, state_nxt;
  logic   last_grant;
  logic   accept;
  logic   win;

  logic [NUM_PORTS-1:0]                 req_vld;
  logic [NUM_PORTS-1:0]                 gnt;
  logic [NUM_PORTS-1:0]                 rsp_ready;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS-1:0][NUM_LANES-1:0]  req_wstrb;
  logic [NUM_PORTS-1:0][DATA_W-1:0]     req_wdata;
  logic [NUM_PORTS-1:0][DATA_W-1:0]     rsp_rdata;

  assign req_vld   = {m1_valid, m0_valid};
  assign req_addr  = {m1_addr,  m0_addr};
  assign req_wstrb = {m1_wstrb, m0_wstrb};
  assign req_wdata = {m1_wdata, m0_wdata};

  rr_arbiter_2 u_arb (
    .req            (req_vld),
    .last_grant     (last_grant),
    .fixed_priority (FIXED_PRIORITY != 0),
    .grant          (gnt)
  );

  // Requests are only looked at while idle; later field changes are ignored.
  assign win    = grant_port(gnt);
  assign accept = (state == IDLE) && (|gnt);

  // State register.
  always_ff @(posedge clk_cpu or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Fixed three-cycle sequence per access; unknown encodings fall to IDLE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = accept ? ISSUE : IDLE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's request into the RAM port; strobe for one cycle only.
  always_ff @(posedge clk_cpu or negedge resetn) begin
    if (!resetn) begin
      ram_sel     <= 1'b0;
      ram_wen     <= '0;
      ram_address <= '0;
      ram_wdata   <= '0;
      grant_id    <= 1'b0;
      last_grant  <= 1'b1;   // port 0 takes the first tie
    end else if (accept) begin
      ram_sel     <= 1'b1;
      ram_wen     <= req_wstrb[win];
      ram_address <= req_addr[win];
      ram_wdata   <= req_wdata[win];
      grant_id    <= win;
      last_grant  <= win;
    end else begin
      ram_sel     <= 1'b0;
      ram_wen     <= '0;
    end
  end

  // Per-port response: ready and read data only for the granted port in RESP.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
    assign rsp_ready[p] = (state == RESP) && (grant_id == 1'(p));
    assign rsp_rdata[p] = rsp_ready[p] ? ram_rdata : '0;
  end

  assign m0_ready = rsp_ready[0];
  assign m1_ready = rsp_ready[1];
  assign m0_rdata = rsp_rdata[0];
  assign m1_rdata = rsp_rdata[1];

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 8 KB RAM macro (4 byte lanes, registered read, one cycle of read latency) between two requesters using the picorv32 native memory handshake.
- Port 0 is the CPU data/instruction bus. Port 1 is a secondary master, e.g. a boot loader or DMA.
- Sits between the bus decode and the RAM instance. It sequences one access at a time and returns a one-cycle ready pulse to the granted requester.

Parameters:
- ADDR_WIDTH, 13: byte-address width presented to the RAM; word address is addr[ADDR_WIDTH-1:2].
- FIXED_PRIORITY, 0: 0 = round-robin between ports; 1 = port 0 always wins ties.

Ports:
- clk_cpu  in  1  system clock; all logic is rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- m0_valid  in  1  port 0 request; held high until m0_ready.
- m0_addr  in  ADDR_WIDTH  port 0 byte address.
- m0_wstrb  in  4  port 0 byte write strobes; 0 = read.
- m0_wdata  in  32  port 0 write data.
- m0_ready  out  1  port 0 completion pulse.
- m0_rdata  out  32  port 0 read data; valid while m0_ready=1.
- m1_valid, m1_addr, m1_wstrb, m1_wdata, m1_ready, m1_rdata: same as port 0, for port 1.
- ram_sel  out  1  RAM clock enable (CEA).
- ram_wen  out  4  RAM per-lane write enables.
- ram_address  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid the cycle after ram_sel.
- grant_id  out  1  port owning the current or most recent access.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE.
  - ram_sel=0, ram_wen=0, ram_address=0, ram_wdata=0.
  - m0_ready=m1_ready=0.
  - grant_id=0.
  - last_grant=1, so port 0 wins the first tie.
- FSM states are IDLE, ISSUE and RESP.
- IDLE:
  - If no valid is high, remain in IDLE.
  - Otherwise select the winner:
    - Only one valid high: that port wins.
    - Both high, FIXED_PRIORITY=1: port 0 wins.
    - Both high, FIXED_PRIORITY=0: the port other than last_grant wins.
  - On the next edge:
    - Register the winner's addr, wstrb and wdata into ram_address, ram_wen and ram_wdata.
    - Set ram_sel=1.
    - Set grant_id and last_grant to the winner.
    - Go to ISSUE.
- ISSUE:
  - The RAM performs the access this cycle.
  - On the next edge: ram_sel=0, ram_wen=0, go to RESP.
- RESP:
  - The granted port's ready=1 for exactly this cycle.
  - Its rdata=ram_rdata, passed through combinationally.
  - The other port's ready=0 and its rdata=0.
  - Next state is IDLE.
- Latency and throughput:
  - Request seen in IDLE at cycle N → RAM access at N+1 → ready at N+2.
  - Maximum one access per 3 cycles.
- Read vs write: handled identically, and ready is returned for writes too. Read data during a write response is don't-care.
- Request stability:
  - The arbiter samples request fields only in IDLE.
  - Changes to a requester's fields while it waits are not observed after grant.
  - A requester that drops valid before its grant is simply not served.
- Back-to-back requests:
  - The requester drops valid after its ready pulse.
  - The RESP→IDLE transition guarantees that port is re-evaluated one cycle after ready.
  - If that port still holds valid (a new request) and both ports are pending, round-robin grants the other port.
  - Net effect: no starvation in round-robin mode; in fixed mode port 1 may starve (intended).
- A losing port keeps waiting with valid high, with no timeout.
- Reset mid-operation:
  - Immediate return to the reset values.
  - Any ready that would have been issued is lost.
  - A write in ISSUE may or may not have been committed to RAM; software must not rely on it.
- Address: ram_address carries the full byte address. The RAM uses only bits [ADDR_WIDTH-1:2]; bits [1:0] are ignored.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, ISSUE=2'd1, RESP=2'd2. Encoding 2'd3 is illegal and must recover to IDLE.
  - RAM geometry constants: data width 32, lane count 4.
- One sub-module is natural: rr_arbiter_2.
  - Inputs: req[1:0], last_grant, fixed_priority.
  - Outputs: a one-hot grant.
  - Purely combinational, and reused by the future peripheral-bus arbiter.

Test Plan:
- Single read, port 0 only: m0 valid, addr=0x0010, wstrb=0 → ram_sel=1 exactly at N+1 with ram_address=0x0010; m0_ready=1 at N+2 and m0_rdata equals the preloaded word 0xDEADBEEF; m1_ready stays 0.
- Byte write, port 1: m1 writes wstrb=4'b0100 with wdata=0x00AA0000 to 0x0020; a subsequent port 0 read of 0x0020 returns the prior word with only bits [23:16] changed to 0xAA.
- Simultaneous requests from reset, FIXED_PRIORITY=0, each port re-requesting after ready: grant order is 0,1,0,1 across 4 accesses; each ready spaced 3 cycles apart; no ready pulse lasts more than 1 cycle.
- FIXED_PRIORITY=1 with port 0 continuously requesting: port 1 is never granted over 10 accesses; once port 0 idles, port 1 completes within 3 cycles.
- Reset asserted during ISSUE: all outputs return to their reset values asynchronously, before the next clock edge; no ready follows; after reset the first tie is granted to port 0.
- Requester withdraws: m1_valid pulses for 1 cycle while port 0 holds the grant → port 1 is never served and m1_ready stays 0.
